// File: rtl/mem_bank_feeder.sv
// Feeds 9 W then 9 X elements from a valid/ready stream into the matrix bank's
// serial load port, then steps the bank through its three unload phases.
module mem_bank_feeder #(
    parameter int DW          = 4,
    parameter int N           = 9,
    parameter int UNLOAD_HOLD = 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          go,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic [DW-1:0] data_in,
    output logic          load_w,
    output logic          load_x,
    output logic          bank_clr,
    output logic          unload1,
    output logic          unload2,
    output logic          unload3,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_SETTLE, S_UNL1, S_UNL2, S_UNL3, S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST  = 4'(N - 1);
    localparam logic [3:0] HOLD_LAST = 4'(UNLOAD_HOLD - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    hcnt_q, hcnt_d;
    logic [DW-1:0] data_q;
    logic          load_w_q, load_x_q, bank_clr_q;
    logic          accept;

    // The handshake is only open in the two load states.
    assign accept = src_valid && ((state_q == S_LOAD_W) || (state_q == S_LOAD_X));

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        src_ready = 1'b0;
        unload1   = 1'b0;
        unload2   = 1'b0;
        unload3   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    state_d = S_LOAD_W;
                    cnt_d   = '0;
                end
            end
            S_LOAD_W: begin
                src_ready = 1'b1;
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_X;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_LOAD_X: begin
                src_ready = 1'b1;
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_SETTLE: begin
                hcnt_d  = '0;
                state_d = S_UNL1;
            end
            S_UNL1, S_UNL2, S_UNL3: begin
                unload1 = (state_q == S_UNL1);
                unload2 = (state_q == S_UNL2);
                unload3 = (state_q == S_UNL3);
                if (hcnt_q == HOLD_LAST) begin
                    hcnt_d = '0;
                    case (state_q)
                        S_UNL1:  state_d = S_UNL2;
                        S_UNL2:  state_d = S_UNL3;
                        default: state_d = S_DONE;
                    endcase
                end else begin
                    hcnt_d = hcnt_q + 4'd1;
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bank-facing strobes are registered: an accept shows up one cycle later.
    always_ff @(posedge clk) begin
        if (clear) begin
            data_q     <= '0;
            load_w_q   <= 1'b0;
            load_x_q   <= 1'b0;
            bank_clr_q <= 1'b0;
        end else begin
            bank_clr_q <= (state_q == S_IDLE) && go;
            load_w_q   <= accept && (state_q == S_LOAD_W);
            load_x_q   <= accept && (state_q == S_LOAD_X);
            if (accept) begin
                data_q <= src_data;
            end
        end
    end

    assign data_in  = data_q;
    assign load_w   = load_w_q;
    assign load_x   = load_x_q;
    assign bank_clr = bank_clr_q;

endmodule
